fetch_sequencer: RTL and testbench

Front-end controller that sequences the dual-issue fetch datapath. It generates the fetch PC and request stream to instruction memory and buffers returned instruction pairs in a circular queue. It presents up to two instructions per cycle to decode and handles branch redirects and stalls. It sits between instruction memory and the decode/dispatch stage, replacing the free-running PC in the fetch unit.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/instr_queue.sv | 75 +++++++
 rtl/fetch_sequencer.sv | 118 +++++++++++
 tb/tb_fetch_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the dual-issue fetch front end.
package fetch_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_queue.sv
// Circular instruction buffer: writes two entries per enqueue, retires up to two per cycle.
module instr_queue #(
  parameter  int DEPTH   = 8,
  parameter  int ADDR_W  = 16,
  parameter  int INSTR_W = 16,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               enq,
  input  logic [ADDR_W-1:0]  enq_pc0,
  input  logic [ADDR_W-1:0]  enq_pc1,
  input  logic [INSTR_W-1:0] enq_instr0,
  input  logic [INSTR_W-1:0] enq_instr1,
  input  logic [1:0]         deq_cnt,
  output logic [CNT_W-1:0]   count,
  output logic [ADDR_W-1:0]  head_pc0,
  output logic [ADDR_W-1:0]  head_pc1,
  output logic [INSTR_W-1:0] head_instr0,
  output logic [INSTR_W-1:0] head_instr1
);

  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [PTR_W-1:0] head_p1, tail_p1;
  logic [CNT_W-1:0] deq_req, deq_eff, enq_amt;

  always_comb begin
    head_p1 = head + PTR_W'(1);
    tail_p1 = tail + PTR_W'(1);
    deq_req = CNT_W'(deq_cnt);
    // A consumer asking for more than is held only retires what is there.
    deq_eff = (deq_req > count) ? count : deq_req;
    enq_amt = enq ? CNT_W'(2) : '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(deq_eff);
      tail  <= enq ? tail + PTR_W'(2) : tail;
      count <= count + enq_amt - deq_eff;
    end
  end

  // NOTE: the storage array carries no reset; occupancy is tracked by count,
  // so stale contents are never presented as valid.
  always_ff @(posedge clk) begin
    if (enq && !flush) begin
      pc_mem[tail]       <= enq_pc0;
      instr_mem[tail]    <= enq_instr0;
      pc_mem[tail_p1]    <= enq_pc1;
      instr_mem[tail_p1] <= enq_instr1;
    end
  end

  assign head_pc0    = pc_mem[head];
  assign head_pc1    = pc_mem[head_p1];
  assign head_instr0 = instr_mem[head];
  assign head_instr1 = instr_mem[head_p1];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch front end: PC generation, paired imem requests, redirect/stall handling,
// and buffering of returned instruction pairs for a dual-issue decoder.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = fetch_pkg::ADDR_W,
  parameter int                INSTR_W  = fetch_pkg::INSTR_W,
  parameter int                DEPTH    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               is_branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr1,
  input  logic [INSTR_W-1:0] imem_instr2,
  output logic               dec_valid1,
  output logic               dec_valid2,
  output logic [INSTR_W-1:0] dec_instr1,
  output logic [INSTR_W-1:0] dec_instr2,
  output logic [ADDR_W-1:0]  dec_pc1,
  output logic [ADDR_W-1:0]  dec_pc2,
  input  logic [1:0]         dec_take
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int NEED_W = CNT_W + 2;

  fetch_state_t       state, state_next;
  logic [ADDR_W-1:0]  pc, resp_pc;
  logic               inflight;
  logic [CNT_W-1:0]   count;
  logic [NEED_W-1:0]  need;
  logic               space_ok, req_ok;
  logic [ADDR_W-1:0]  head_pc0, head_pc1;
  logic [INSTR_W-1:0] head_instr0, head_instr1;

  // Space is reserved for the queued entries, the pair still in flight and the
  // new pair; only registered count is used so dec_take has no path to imem_req.
  always_comb begin
    need     = NEED_W'(count) + (inflight ? NEED_W'(4) : NEED_W'(2));
    space_ok = (need <= NEED_W'(DEPTH));
    req_ok   = (state != IDLE) && !stall && !is_branch_taken && space_ok;
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    case (state)
      IDLE:    state_next = RUN;
      RUN: begin
        imem_req = req_ok;
        if (!req_ok) state_next = HOLD;
      end
      HOLD:    if (req_ok) state_next = RUN;
      default: state_next = IDLE;
    endcase
    if (is_branch_taken) state_next = RUN;
  end

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      resp_pc  <= '0;
      inflight <= 1'b0;
    end else begin
      state <= state_next;
      if (is_branch_taken) begin
        pc       <= branch_target;
        inflight <= 1'b0;
      end else if (imem_req) begin
        pc       <= pc + ADDR_W'(2);
        resp_pc  <= pc;
        inflight <= 1'b1;
      end else begin
        inflight <= 1'b0;
      end
    end
  end

  // A redirect kills the response landing in its cycle and freezes dequeue.
  instr_queue #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_queue (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (is_branch_taken),
    .enq         (inflight && !is_branch_taken),
    .enq_pc0     (resp_pc),
    .enq_pc1     (resp_pc + ADDR_W'(1)),
    .enq_instr0  (imem_instr1),
    .enq_instr1  (imem_instr2),
    .deq_cnt     (is_branch_taken ? 2'd0 : dec_take),
    .count       (count),
    .head_pc0    (head_pc0),
    .head_pc1    (head_pc1),
    .head_instr0 (head_instr0),
    .head_instr1 (head_instr1)
  );

  assign dec_valid1 = (count != '0);
  assign dec_valid2 = (count > CNT_W'(1));
  assign dec_pc1    = dec_valid1 ? head_pc0    : '0;
  assign dec_pc2    = dec_valid2 ? head_pc1    : '0;
  assign dec_instr1 = dec_valid1 ? head_instr0 : '0;
  assign dec_instr2 = dec_valid2 ? head_instr1 : '0;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: the expected decode stream is the
// program-order address sequence, restarted on every redirect or reset.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam int          DEPTH    = 8;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               stall = 1'b0;
  logic               is_branch_taken = 1'b0;
  logic [ADDR_W-1:0]  branch_target = '0;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr1 = '0;
  logic [INSTR_W-1:0] imem_instr2 = '0;
  logic               dec_valid1, dec_valid2;
  logic [INSTR_W-1:0] dec_instr1, dec_instr2;
  logic [ADDR_W-1:0]  dec_pc1, dec_pc2;
  logic [1:0]         dec_take = 2'd0;

  fetch_sequencer #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .stall           (stall),
    .is_branch_taken (is_branch_taken),
    .branch_target   (branch_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_instr1     (imem_instr1),
    .imem_instr2     (imem_instr2),
    .dec_valid1      (dec_valid1),
    .dec_valid2      (dec_valid2),
    .dec_instr1      (dec_instr1),
    .dec_instr2      (dec_instr2),
    .dec_pc1         (dec_pc1),
    .dec_pc2         (dec_pc2),
    .dec_take        (dec_take)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory contents: a fixed scramble of the address, so pc and instr differ.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[10:0], a[15:11]} ^ 16'h5AC3;
  endfunction

  // Instruction memory: answers a request seen in one cycle during the next.
  logic        mem_req_q = 1'b0;
  logic [15:0] mem_addr_q = '0;
  always @(negedge clk) begin
    mem_req_q  = imem_req;
    mem_addr_q = imem_addr;
  end
  always @(posedge clk) begin
    #1;
    if (mem_req_q) begin
      imem_instr1 = mem_word(mem_addr_q);
      imem_instr2 = mem_word(mem_addr_q + 16'd1);
    end else begin
      imem_instr1 = 16'($urandom);
      imem_instr2 = 16'($urandom);
    end
  end

  // Scoreboard: expected decode entries tagged with the stream epoch.
  typedef struct {
    int           epoch;
    fetch_entry_t e;
  } exp_t;

  exp_t        exp_q[$];
  int          epoch = 0;
  int          mon_epoch = 0;
  logic [15:0] stream_pc = RESET_PC;

  task automatic top_up();
    int   n;
    exp_t x;
    n = 0;
    foreach (exp_q[i]) if (exp_q[i].epoch == epoch) n++;
    while (n < 4) begin
      x.epoch   = epoch;
      x.e.pc    = stream_pc;
      x.e.instr = mem_word(stream_pc);
      exp_q.push_back(x);
      stream_pc = stream_pc + 16'd1;
      n++;
    end
  endtask

  // Monitor: compares whatever the decode port presents against the scoreboard.
  logic        rst_evt = 1'b0;
  logic        prev_branch = 1'b0;
  logic [15:0] prev_target = '0;
  always @(negedge reset_n) rst_evt = 1'b1;

  always @(negedge clk) begin : monitor
    int nv, k;
    if (!reset_n) begin
      check("rst_valid1", dec_valid1, 0);
      check("rst_req", imem_req, 0);
      mon_epoch   = epoch;
      prev_branch = 1'b0;
      rst_evt     = 1'b0;
    end else begin
      if (rst_evt) begin
        mon_epoch   = epoch;
        prev_branch = 1'b0;
        rst_evt     = 1'b0;
      end
      while (exp_q.size() > 0 && exp_q[0].epoch < mon_epoch) void'(exp_q.pop_front());
      if (dec_valid1) begin
        if (exp_q.size() < 1) check("sb_underflow1", 1, 0);
        else begin
          check("dec_pc1", dec_pc1, exp_q[0].e.pc);
          check("dec_instr1", dec_instr1, exp_q[0].e.instr);
        end
      end else begin
        check("idle_pc1", dec_pc1, 0);
        check("idle_instr1", dec_instr1, 0);
      end
      if (dec_valid2) begin
        check("valid2_implies_valid1", dec_valid1, 1);
        if (exp_q.size() < 2) check("sb_underflow2", 1, 0);
        else begin
          check("dec_pc2", dec_pc2, exp_q[1].e.pc);
          check("dec_instr2", dec_instr2, exp_q[1].e.instr);
        end
      end else begin
        check("idle_pc2", dec_pc2, 0);
        check("idle_instr2", dec_instr2, 0);
      end
      if (stall || is_branch_taken) check("blocked_req", imem_req, 0);
      if (prev_branch) begin
        check("redir_flush", dec_valid1, 0);
        if (!stall && !is_branch_taken) begin
          check("redir_req", imem_req, 1);
          check("redir_addr", imem_addr, prev_target);
        end
      end
      if (!is_branch_taken) begin
        nv = int'(dec_valid1) + int'(dec_valid2);
        k  = (int'(dec_take) > nv) ? nv : int'(dec_take);
        repeat (k) if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
        mon_epoch++;
      end
      prev_branch = is_branch_taken;
      prev_target = branch_target;
    end
  end

  // Drive one cycle of inputs just after the edge; return at the falling edge.
  task automatic cycle(input logic s, input logic b, input logic [15:0] t, input logic [1:0] k);
    @(posedge clk);
    #1;
    top_up();
    stall           = s;
    is_branch_taken = b;
    branch_target   = t;
    dec_take        = k;
    if (b) begin
      epoch++;
      stream_pc = t;
      top_up();
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    stall = 1'b0; is_branch_taken = 1'b0; dec_take = 2'd0;
    epoch++;
    stream_pc = RESET_PC;
    reset_n   = 1'b0;
    #1;
    check("async_req", imem_req, 0);
    check("async_addr", imem_addr, RESET_PC);
    check("async_valid1", dec_valid1, 0);
    check("async_valid2", dec_valid2, 0);
    check("async_pc1", dec_pc1, 0);
    check("async_instr1", dec_instr1, 0);
    #1;
    reset_n = 1'b1;
    top_up();
    @(negedge clk);
  endtask

  // Called at the falling edge of the first post-reset cycle (cycle 0).
  task automatic first_sequence();
    check("c0_req", imem_req, 0);
    check("c0_addr", imem_addr, RESET_PC);
    check("c0_valid", dec_valid1, 0);
    cycle(0, 0, 16'h0, 2'd0);
    check("c1_req", imem_req, 1);
    check("c1_addr", imem_addr, RESET_PC);
    cycle(0, 0, 16'h0, 2'd0);
    check("c2_valid", dec_valid1, 0);
    check("c2_addr", imem_addr, 16'h0002);
    cycle(0, 0, 16'h0, 2'd2);
    check("c3_valid2", dec_valid2, 1);
    check("c3_pc1", dec_pc1, 16'h0000);
    check("c3_pc2", dec_pc2, 16'h0001);
    check("c3_instr1", dec_instr1, mem_word(16'h0000));
    cycle(0, 0, 16'h0, 2'd2);
    check("c4_valid2", dec_valid2, 1);
    check("c4_pc1", dec_pc1, 16'h0002);
    check("c4_pc2", dec_pc2, 16'h0003);
  endtask

  task automatic redirect_to(input logic [15:0] t, input logic [15:0] p1, input logic [15:0] p2,
                             input logic [15:0] q1, input logic [15:0] q2);
    cycle(0, 1, t, 2'd2);
    cycle(0, 0, 16'h0, 2'd0);
    check("r1_valid", dec_valid1, 0);
    check("r1_req", imem_req, 1);
    check("r1_addr", imem_addr, t);
    cycle(0, 0, 16'h0, 2'd0);
    check("r2_valid", dec_valid1, 0);
    cycle(0, 0, 16'h0, 2'd2);
    check("r3_valid2", dec_valid2, 1);
    check("r3_pc1", dec_pc1, p1);
    check("r3_pc2", dec_pc2, p2);
    check("r3_instr1", dec_instr1, mem_word(p1));
    cycle(0, 0, 16'h0, 2'd2);
    check("r4_valid2", dec_valid2, 1);
    check("r4_pc1", dec_pc1, q1);
    check("r4_pc2", dec_pc2, q2);
  endtask

  initial begin : stimulus
    logic [15:0] addrs[$];
    logic        s, b;
    logic [15:0] t;
    logic [1:0]  k;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid2", dec_valid2, 0);
    check("rst_pc1", dec_pc1, 0);
    check("rst_instr2", dec_instr2, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    top_up();
    @(negedge clk);
    first_sequence();

    repeat (6) begin
      cycle(0, 0, 16'h0, 2'd2);
      check("steady_valid2", dec_valid2, 1);
      check("steady_req", imem_req, 1);
    end

    // Stall with a pair in flight: it must still land while the queue drains.
    cycle(1, 0, 16'h0, 2'd1);
    check("stall_s0_valid2", dec_valid2, 1);
    cycle(1, 0, 16'h0, 2'd1);
    check("stall_s1_valid2", dec_valid2, 1);
    cycle(1, 0, 16'h0, 2'd1);
    check("stall_s2_valid2", dec_valid2, 1);
    cycle(0, 0, 16'h0, 2'd0);
    check("stall_s3_valid1", dec_valid1, 1);
    check("stall_s3_valid2", dec_valid2, 0);
    check("stall_s3_req", imem_req, 0);
    cycle(0, 0, 16'h0, 2'd0);
    check("stall_s4_req", imem_req, 1);
    repeat (5) cycle(0, 0, 16'h0, 2'd2);

    redirect_to(16'h0005, 16'h0005, 16'h0006, 16'h0007, 16'h0008);
    redirect_to(16'hFFFE, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001);
    redirect_to(16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002);

    pulse_reset();
    first_sequence();

    // Hold the decoder off: the queue fills and fetching parks.
    pulse_reset();
    repeat (12) begin
      cycle(0, 0, 16'h0, 2'd0);
      if (imem_req) addrs.push_back(imem_addr);
    end
    check("full_nreq", addrs.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < addrs.size()) check("full_addr", addrs[i], RESET_PC + 16'(2 * i));
    check("full_valid2", dec_valid2, 1);
    cycle(0, 0, 16'h0, 2'd2);
    addrs.delete();
    repeat (8) begin
      cycle(0, 0, 16'h0, 2'd0);
      if (imem_req) addrs.push_back(imem_addr);
    end
    check("refill_nreq", addrs.size(), 1);
    if (addrs.size() > 0) check("refill_addr", addrs[0], 16'h0008);

    repeat (3000) begin
      s = ($urandom_range(0, 9) == 0);
      b = ($urandom_range(0, 24) == 0);
      t = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
      k = 2'($urandom_range(0, 2));
      cycle(s, b, t, k);
    end
    repeat (6) cycle(0, 0, 16'h0, 2'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
